// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium host interface: FSM state codes,
// core key/IV widths and the default warm-up length.
package trivium_pkg;

  localparam int unsigned KEY_BITS           = 80;
  localparam int unsigned IV_BITS            = 80;
  localparam int unsigned INIT_STEPS_DEFAULT = 1152;
  localparam int unsigned BYTE_BITS          = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_KEY  = 3'd0;
  localparam state_t S_IV   = 3'd1;
  localparam state_t S_LOAD = 3'd2;
  localparam state_t S_INIT = 3'd3;
  localparam state_t S_IDLE = 3'd4;
  localparam state_t S_GEN  = 3'd5;
  localparam state_t S_OUT  = 3'd6;

  // States in which the host may push a byte.
  function automatic logic accepts_input(input state_t s);
    return (s == S_KEY) || (s == S_IV) || (s == S_IDLE);
  endfunction

  // States in which the core is clocked forward.
  function automatic logic steps_core(input state_t s);
    return (s == S_INIT) || (s == S_GEN);
  endfunction

endpackage

// File: rtl/trivium_host_if.sv
// Byte-wide host front end for a Trivium keystream core: loads key/IV,
// runs the warm-up, then encrypts one byte at a time with backpressure.
module trivium_host_if
  import trivium_pkg::*;
#(
  parameter int unsigned INIT_STEPS = INIT_STEPS_DEFAULT,
  parameter int unsigned KEY_BYTES  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                rekey,
  output logic [KEY_BITS-1:0] core_key,
  output logic [IV_BITS-1:0]  core_iv,
  output logic                core_load,
  output logic                core_step,
  input  logic                core_ks
);

  localparam int unsigned ICW       = $clog2(INIT_STEPS + 1);
  localparam logic [3:0]  LAST_BYTE = 4'(KEY_BYTES - 1);
  localparam logic [ICW-1:0] LAST_INIT = ICW'(INIT_STEPS - 1);

  state_t                state_q, state_d;
  logic [3:0]            byte_cnt_q, byte_cnt_d;
  logic [ICW-1:0]        init_cnt_q, init_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [IV_BITS-1:0]    iv_q, iv_d;
  logic [BYTE_BITS-1:0]  data_q, data_d;
  logic [BYTE_BITS-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  core_load_q, core_load_d;
  logic                  core_step_q, core_step_d;

  logic                  in_xfer_c;
  logic                  out_xfer_c;
  logic [6:0]            byte_sh_c;
  logic [BYTE_BITS-1:0]  gen_byte_c;

  // Next-state and datapath logic; rekey overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    init_cnt_d  = init_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    key_d       = key_q;
    iv_d        = iv_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    in_xfer_c  = in_valid & in_ready_q;
    out_xfer_c = out_valid_q & out_ready;
    // Byte n of key/IV lands MSB-first: first byte at the top.
    byte_sh_c  = 7'(KEY_BITS - 8) - {byte_cnt_q, 3'b000};
    gen_byte_c = data_q ^ (8'(core_ks) << bit_cnt_q);

    case (state_q)
      S_KEY: begin
        if (in_xfer_c) begin
          key_d = (key_q & ~(KEY_BITS'(8'hFF) << byte_sh_c)) |
                  (KEY_BITS'(in_data) << byte_sh_c);
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = 4'd0;
            state_d    = S_IV;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      S_IV: begin
        if (in_xfer_c) begin
          iv_d = (iv_q & ~(IV_BITS'(8'hFF) << byte_sh_c)) |
                 (IV_BITS'(in_data) << byte_sh_c);
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = 4'd0;
            state_d    = S_LOAD;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      S_LOAD: begin
        init_cnt_d = '0;
        state_d    = S_INIT;
      end
      S_INIT: begin
        if (init_cnt_q == LAST_INIT) begin
          init_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + ICW'(1);
        end
      end
      S_IDLE: begin
        if (in_xfer_c) begin
          data_d    = in_data;
          bit_cnt_d = 3'd0;
          state_d   = S_GEN;
        end
      end
      S_GEN: begin
        data_d = gen_byte_c;
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d   = 3'd0;
          out_data_d  = gen_byte_c;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      S_OUT: begin
        if (out_xfer_c) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_KEY;
    endcase

    // Key and IV registers are deliberately kept across a rekey.
    if (rekey) begin
      state_d     = S_KEY;
      byte_cnt_d  = 4'd0;
      init_cnt_d  = '0;
      bit_cnt_d   = 3'd0;
      key_d       = key_q;
      iv_d        = iv_q;
      data_d      = '0;
      out_valid_d = 1'b0;
    end

    in_ready_d  = accepts_input(state_d);
    core_load_d = (state_d == S_LOAD);
    core_step_d = steps_core(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_KEY;
      byte_cnt_q  <= 4'd0;
      init_cnt_q  <= '0;
      bit_cnt_q   <= 3'd0;
      key_q       <= '0;
      iv_q        <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      core_load_q <= 1'b0;
      core_step_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      init_cnt_q  <= init_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      key_q       <= key_d;
      iv_q        <= iv_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      core_load_q <= core_load_d;
      core_step_q <= core_step_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign core_key  = key_q;
  assign core_iv   = iv_q;
  assign core_load = core_load_q;
  assign core_step = core_step_q;

endmodule

// File: tb/tb_trivium_host_if.sv
// Self-checking bench for trivium_host_if with a stub keystream source and
// a behavioural Trivium core standing beside the DUT.
module tb_trivium_host_if;
  import trivium_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        rekey;
  logic [79:0] core_key;
  logic [79:0] core_iv;
  logic        core_load;
  logic        core_step;
  logic        core_ks;

  trivium_host_if #(.INIT_STEPS(1152), .KEY_BYTES(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rekey     (rekey),
    .core_key  (core_key),
    .core_iv   (core_iv),
    .core_load (core_load),
    .core_step (core_step),
    .core_ks   (core_ks)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Cycle counters for core_step / core_load, written only here.
  int step_cnt = 0;
  int load_cnt = 0;
  always @(posedge clk) begin
    if (core_step) step_cnt <= step_cnt + 1;
    if (core_load) load_cnt <= load_cnt + 1;
  end

  // Behavioural Trivium state: s[i] holds s_(i+1) of the cipher description.
  bit [287:0] s;
  logic       z_c;
  assign z_c = s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];

  function automatic bit [287:0] triv_load(input logic [79:0] k, input logic [79:0] v);
    bit [287:0] r;
    r = '0;
    r[79:0]    = k;
    r[172:93]  = v;
    r[287:285] = 3'b111;
    return r;
  endfunction

  function automatic bit [287:0] triv_next(input bit [287:0] x);
    bit t1, t2, t3;
    bit [287:0] r;
    t1 = x[65] ^ x[92] ^ (x[90] & x[91]) ^ x[170];
    t2 = x[161] ^ x[176] ^ (x[174] & x[175]) ^ x[263];
    t3 = x[242] ^ x[287] ^ (x[285] & x[286]) ^ x[68];
    r = x;
    r[92:0]    = {x[91:0], t3};
    r[176:93]  = {x[175:93], t1};
    r[287:177] = {x[286:177], t2};
    return r;
  endfunction

  always @(posedge clk) begin
    if (core_load)      s <= triv_load(core_key, core_iv);
    else if (core_step) s <= triv_next(s);
  end

  // Keystream source: either a fixed 8-bit pattern (bit k on the k-th step
  // after stub_base) or the behavioural core.
  logic       use_stub;
  logic [7:0] stub_pat;
  int         stub_base;
  assign core_ks = use_stub ? stub_pat[3'(step_cnt - stub_base)] : z_c;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [79:0] v, input int i);
    return 8'(v >> (72 - 8 * i));
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) timeout("in_ready_wait");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [79:0] k, input logic [79:0] v);
    for (int i = 0; i < 10; i++) send_byte(byte_of(k, i));
    for (int i = 0; i < 10; i++) send_byte(byte_of(v, i));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !core_step && !out_valid) && n < 3000) begin
      tick();
      n++;
    end
    if (!(in_ready && !core_step && !out_valid)) timeout("idle_wait");
  endtask

  task automatic pulse_rekey();
    rekey = 1'b1;
    tick();
    rekey = 1'b0;
  endtask

  // One plaintext byte through the block; returns ciphertext and latency.
  task automatic do_byte(input logic [7:0] pt, input int stall,
                         output logic [7:0] ct, output int lat);
    logic [7:0] first;
    stub_base = step_cnt;
    send_byte(pt);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) timeout("out_valid_wait");
    first = out_data;
    for (int i = 0; i < stall; i++) tick();
    ct = out_data;
    if (stall > 0) check("out_hold", 80'(ct), 80'(first));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_release", 80'(out_valid), 80'(0));
  endtask

  typedef struct {
    logic [7:0] pt;
    logic [7:0] ks;
    logic [7:0] exp;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  ct, held;
  int          lat, st0, ld0, n;
  int          bad_data, bad_step, bad_ready, bad_valid;
  logic [79:0] k2, v2, k3, v3;
  logic [7:0]  pts[16];
  logic [7:0]  cts[16];

  initial begin
    rst_n = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; rekey = 1'b0;
    use_stub = 1'b1; stub_pat = '0; stub_base = 0;
    #1 rst_n = 1'b0;
    #11;
    check("rst_in_ready",  80'(in_ready),  80'(1));
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_out_data",  80'(out_data),  80'(0));
    check("rst_core_load", 80'(core_load), 80'(0));
    check("rst_core_step", 80'(core_step), 80'(0));
    check("rst_core_key",  core_key, 80'(0));
    check("rst_core_iv",   core_iv,  80'(0));

    // Load straight after release, then measure load pulse and warm-up length.
    @(posedge clk); #1 rst_n = 1'b1;
    ld0 = load_cnt; st0 = step_cnt;
    load_key(80'h00010203040506070809, 80'h0A0B0C0D0E0F10111213);
    check("key_bytes", core_key, 80'h00010203040506070809);
    check("iv_bytes",  core_iv,  80'h0A0B0C0D0E0F10111213);
    wait_idle();
    check("load_cycles", 80'(load_cnt - ld0), 80'(1));
    check("init_steps",  80'(step_cnt - st0), 80'(1152));

    // 0xA5 with keystream 1,0,1,1,0,0,0,1 then 50 cycles of backpressure.
    stub_pat = 8'h8D;
    stub_base = step_cnt;
    send_byte(8'hA5);
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check("a5_latency", 80'(lat), 80'(9));
    check("a5_cipher",  80'(out_data), 80'(8'h28));
    held = out_data; st0 = step_cnt;
    bad_data = 0; bad_step = 0; bad_ready = 0; bad_valid = 0;
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (out_data !== held) bad_data++;
      if (core_step !== 1'b0) bad_step++;
      if (in_ready !== 1'b0) bad_ready++;
      if (out_valid !== 1'b1) bad_valid++;
    end
    in_valid = 1'b0;
    check("stall_data",  80'(bad_data),  80'(0));
    check("stall_step",  80'(bad_step),  80'(0));
    check("stall_ready", 80'(bad_ready), 80'(0));
    check("stall_valid", 80'(bad_valid), 80'(0));
    check("stall_no_ks", 80'(step_cnt - st0), 80'(0));
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("release_valid", 80'(out_valid), 80'(0));
    check("release_ready", 80'(in_ready),  80'(1));

    // Fixed vectors: bit ordering and extremes.
    tbl[0] = '{8'hA5, 8'h8D, 8'h28};
    tbl[1] = '{8'h00, 8'h00, 8'h00};
    tbl[2] = '{8'hFF, 8'hFF, 8'h00};
    tbl[3] = '{8'h00, 8'h01, 8'h01};
    tbl[4] = '{8'h00, 8'h80, 8'h80};
    tbl[5] = '{8'h3C, 8'hF0, 8'hCC};
    for (int i = 0; i < 6; i++) begin
      stub_pat = tbl[i].ks;
      do_byte(tbl[i].pt, 0, ct, lat);
      check("tbl_cipher",  80'(ct),  80'(tbl[i].exp));
      check("tbl_latency", 80'(lat), 80'(9));
    end

    // Random bytes, keystreams, gaps and stalls against pt ^ keystream.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] pt;
      pt = 8'($urandom);
      stub_pat = 8'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      do_byte(pt, int'($urandom_range(0, 5)), ct, lat);
      check("rnd_cipher",  80'(ct),  80'(pt ^ stub_pat));
      check("rnd_latency", 80'(lat), 80'(9));
    end

    // Rekey beats a simultaneous plaintext transfer; key/IV registers persist.
    in_valid = 1'b1; in_data = 8'h11;
    pulse_rekey();
    in_valid = 1'b0;
    tick();
    check("rk_idle_ready", 80'(in_ready),  80'(1));
    check("rk_idle_step",  80'(core_step), 80'(0));
    check("rk_idle_valid", 80'(out_valid), 80'(0));
    check("rk_key_kept",   core_key, 80'h00010203040506070809);

    // Partial key then rekey: byte counter must restart at byte 0.
    k2 = 80'hDEADBEEF0123456789AB;
    v2 = 80'h13579BDF02468ACE1122;
    for (int i = 0; i < 3; i++) send_byte(8'hEE);
    pulse_rekey();
    load_key(k2, v2);
    check("rk_partial_key", core_key, k2);
    check("rk_partial_iv",  core_iv,  v2);
    n = 0;
    while (!core_step && n < 20) begin tick(); n++; end
    if (!core_step) timeout("init_start");
    st0 = step_cnt;
    n = 0;
    while (step_cnt - st0 < 500 && n < 2000) begin tick(); n++; end
    pulse_rekey();
    check("rk_init_step",  80'(core_step), 80'(0));
    check("rk_init_ready", 80'(in_ready),  80'(1));
    tick();
    check("rk_init_count", 80'(step_cnt - st0), 80'(501));
    ld0 = load_cnt; st0 = step_cnt;
    load_key(k2, v2);
    wait_idle();
    check("reload_load",  80'(load_cnt - ld0), 80'(1));
    check("reload_steps", 80'(step_cnt - st0), 80'(1152));

    // Real keystream: encrypt, rekey with the same key/IV, decrypt.
    use_stub = 1'b0;
    k3 = {16'($urandom), 32'($urandom), 32'($urandom)};
    v3 = {16'($urandom), 32'($urandom), 32'($urandom)};
    pulse_rekey();
    load_key(k3, v3);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      pts[i] = 8'($urandom);
      do_byte(pts[i], int'($urandom_range(0, 3)), cts[i], lat);
    end
    pulse_rekey();
    load_key(k3, v3);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      do_byte(cts[i], int'($urandom_range(0, 3)), ct, lat);
      check("roundtrip", 80'(ct), 80'(pts[i]));
    end

    // Asynchronous reset in the middle of generation.
    use_stub = 1'b1; stub_pat = 8'hFF;
    stub_base = step_cnt;
    send_byte(8'h5A);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #2;
    check("arst_in_ready",  80'(in_ready),  80'(1));
    check("arst_out_valid", 80'(out_valid), 80'(0));
    check("arst_out_data",  80'(out_data),  80'(0));
    check("arst_core_step", 80'(core_step), 80'(0));
    check("arst_core_load", 80'(core_load), 80'(0));
    check("arst_core_key",  core_key, 80'(0));
    check("arst_core_iv",   core_iv,  80'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
